// File: rtl/pwm_gen_if.sv
// PWM channel bus: enable and requested duty in, waveform and period marker out.
interface pwm_gen_if #(
  parameter int WIDTH = 7
);
  logic             en;
  logic [WIDTH-1:0] value_input;
  logic             out;
  logic             period_start;

  modport master (output en, output value_input, input out, input period_start);
  modport slave  (input en, input value_input, output out, output period_start);
endinterface

// File: rtl/pwm_gen.sv
// Prescaled PWM generator with a shadow duty register; out/period_start are registered (1 clk latency).
// No backpressure: free-running while en=1; en=0 parks the counters and tracks value_input.
module pwm_gen #(
  parameter int WIDTH    = 7,
  parameter int PRESCALE = 1
) (
  input logic       clk,
  input logic       rst,
  pwm_gen_if.slave  bus
);
  localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_LAST = '1;

  logic [PW-1:0]    pre;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty_q;
  logic             out_q;
  logic             period_start_q;
  logic             tick;
  logic             wrap;

  assign tick = (pre == PRE_LAST);
  assign wrap = tick && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre            <= '0;
      cnt            <= '0;
      duty_q         <= '0;
      out_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else if (!bus.en) begin
      // Parked: the next enable starts a clean period with the last sampled duty.
      pre            <= '0;
      cnt            <= '0;
      duty_q         <= bus.value_input;
      out_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      if (tick) begin
        pre <= '0;
        cnt <= cnt + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
      if (wrap) begin
        duty_q <= bus.value_input;
      end
      out_q          <= (cnt < duty_q);
      period_start_q <= wrap;
    end
  end

  assign bus.out          = out_q;
  assign bus.period_start = period_start_q;
endmodule

// File: tb/tb_pwm_gen.sv
// Bench for pwm_gen: cycle scoreboard on a PRESCALE=1 channel plus per-period counts, and a PRESCALE=4 channel.
module tb_pwm_gen;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  logic [1:0] sb[$];
  logic [1:0] exp_v;
  int   mn;
  int   mduty;

  pwm_gen_if #(.WIDTH(7)) bus1 ();
  pwm_gen_if #(.WIDTH(7)) bus4 ();

  pwm_gen #(.WIDTH(7), .PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  pwm_gen #(.WIDTH(7), .PRESCALE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference for the PRESCALE=1 channel, expressed as clocks elapsed since enable.
  always @(posedge clk) begin
    if (rst) begin
      mn    <= 0;
      mduty <= 0;
      sb.push_back(2'b00);
    end else if (!bus1.en) begin
      mn    <= 0;
      mduty <= int'(bus1.value_input);
      sb.push_back(2'b00);
    end else begin
      sb.push_back({((mn % 128) < mduty) ? 1'b1 : 1'b0, ((mn % 128) == 127) ? 1'b1 : 1'b0});
      mn <= mn + 1;
      if ((mn % 128) == 127) mduty <= int'(bus1.value_input);
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_v = (sb.size() > 0) ? sb.pop_front() : 2'bxx;
      n_chk++;
      if ({bus1.out, bus1.period_start} !== exp_v) begin
        n_fail++;
        $display("FAIL reset_sb cyc %0d: got %b want %b", i, {bus1.out, bus1.period_start}, exp_v);
      end
      n_chk++;
      if ({bus4.out, bus4.period_start} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_p4 cyc %0d: got %b want 00", i, {bus4.out, bus4.period_start});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_duty(input int v, input bit restart, input int exp_hi);
    int psn;
    int win;
    int last;
    psn = 0; win = 0; last = -1;
    bus1.value_input = 7'(v);
    if (restart) begin
      bus1.en = 1'b0;
      @(negedge clk);
      exp_v = (sb.size() > 0) ? sb.pop_front() : 2'bxx;
      n_chk++;
      if ({bus1.out, bus1.period_start} !== exp_v) begin
        n_fail++;
        $display("FAIL duty%0d_park: got %b want %b", v, {bus1.out, bus1.period_start}, exp_v);
      end
    end
    bus1.en = 1'b1;
    for (int i = 0; i < 768; i++) begin
      @(negedge clk);
      exp_v = (sb.size() > 0) ? sb.pop_front() : 2'bxx;
      n_chk++;
      if ({bus1.out, bus1.period_start} !== exp_v) begin
        n_fail++;
        $display("FAIL duty%0d_sb cyc %0d: got %b want %b", v, i, {bus1.out, bus1.period_start}, exp_v);
      end
      if (bus1.period_start === 1'b1) begin
        if (psn >= 2) begin
          n_chk++;
          if (win !== exp_hi) begin
            n_fail++;
            $display("FAIL duty%0d_high_per_period: got %0d want %0d", v, win, exp_hi);
          end
          n_chk++;
          if (i - last !== 128) begin
            n_fail++;
            $display("FAIL duty%0d_pulse_spacing: got %0d want 128", v, i - last);
          end
        end
        psn++; last = i; win = 0;
      end
      if (bus1.out === 1'b1) win++;
    end
    n_chk++;
    if (psn < 5) begin
      n_fail++;
      $display("FAIL duty%0d_pulse_count: got %0d want >=5", v, psn);
    end
  endtask

  task automatic test_mid_change();
    int hi0;
    int hi1;
    hi0 = 0; hi1 = 0;
    bus1.en = 1'b0;
    bus1.value_input = 7'd10;
    @(negedge clk);
    exp_v = (sb.size() > 0) ? sb.pop_front() : 2'bxx;
    bus1.en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      exp_v = (sb.size() > 0) ? sb.pop_front() : 2'bxx;
      n_chk++;
      if ({bus1.out, bus1.period_start} !== exp_v) begin
        n_fail++;
        $display("FAIL midchg_sb cyc %0d: got %b want %b", i, {bus1.out, bus1.period_start}, exp_v);
      end
      if (bus1.out === 1'b1) begin
        if (i < 128) hi0++;
        else hi1++;
      end
      if (i == 50) bus1.value_input = 7'd100;
    end
    n_chk++;
    if (hi0 !== 10) begin
      n_fail++;
      $display("FAIL midchg_current_period: got %0d highs want 10", hi0);
    end
    n_chk++;
    if (hi1 !== 100) begin
      n_fail++;
      $display("FAIL midchg_next_period: got %0d highs want 100", hi1);
    end
  endtask

  task automatic test_en_drop();
    int hi;
    hi = 0;
    bus1.en = 1'b0;
    bus1.value_input = 7'd40;
    @(negedge clk);
    exp_v = (sb.size() > 0) ? sb.pop_front() : 2'bxx;
    bus1.en = 1'b1;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      exp_v = (sb.size() > 0) ? sb.pop_front() : 2'bxx;
      n_chk++;
      if ({bus1.out, bus1.period_start} !== exp_v) begin
        n_fail++;
        $display("FAIL endrop_run_sb cyc %0d: got %b want %b", i, {bus1.out, bus1.period_start}, exp_v);
      end
    end
    bus1.en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      exp_v = (sb.size() > 0) ? sb.pop_front() : 2'bxx;
      n_chk++;
      if (bus1.out !== 1'b0) begin
        n_fail++;
        $display("FAIL endrop_out_low cyc %0d: got %b want 0", i, bus1.out);
      end
    end
    bus1.en = 1'b1;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      exp_v = (sb.size() > 0) ? sb.pop_front() : 2'bxx;
      n_chk++;
      if ({bus1.out, bus1.period_start} !== exp_v) begin
        n_fail++;
        $display("FAIL endrop_restart_sb cyc %0d: got %b want %b", i, {bus1.out, bus1.period_start}, exp_v);
      end
      if (bus1.out === 1'b1) hi++;
    end
    n_chk++;
    if (hi !== 40) begin
      n_fail++;
      $display("FAIL endrop_restart_highs: got %0d want 40", hi);
    end
  endtask

  task automatic test_reset_mid();
    int hi0;
    int hi1;
    int ps_at;
    hi0 = 0; hi1 = 0; ps_at = -1;
    bus1.value_input = 7'd50;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      exp_v = (sb.size() > 0) ? sb.pop_front() : 2'bxx;
    end
    rst = 1'b1;
    @(negedge clk);
    exp_v = (sb.size() > 0) ? sb.pop_front() : 2'bxx;
    n_chk++;
    if ({bus1.out, bus1.period_start} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %b want 00", {bus1.out, bus1.period_start});
    end
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      exp_v = (sb.size() > 0) ? sb.pop_front() : 2'bxx;
      n_chk++;
      if ({bus1.out, bus1.period_start} !== exp_v) begin
        n_fail++;
        $display("FAIL rstmid_sb cyc %0d: got %b want %b", i, {bus1.out, bus1.period_start}, exp_v);
      end
      if (bus1.out === 1'b1) begin
        if (i < 128) hi0++;
        else hi1++;
      end
      if (bus1.period_start === 1'b1 && ps_at < 0) ps_at = i;
    end
    n_chk++;
    if (hi0 !== 0) begin
      n_fail++;
      $display("FAIL rstmid_duty_cleared: got %0d highs want 0", hi0);
    end
    n_chk++;
    if (hi1 !== 50) begin
      n_fail++;
      $display("FAIL rstmid_reload: got %0d highs want 50", hi1);
    end
    n_chk++;
    if (ps_at !== 127) begin
      n_fail++;
      $display("FAIL rstmid_first_pulse: got cyc %0d want 127", ps_at);
    end
  endtask

  task automatic test_prescale();
    int hi0;
    int hi1;
    int psn;
    int ps_first;
    int ps_last;
    hi0 = 0; hi1 = 0; psn = 0; ps_first = -1; ps_last = -1;
    bus1.en = 1'b0;
    bus4.en = 1'b0;
    bus4.value_input = 7'd16;
    @(negedge clk);
    exp_v = (sb.size() > 0) ? sb.pop_front() : 2'bxx;
    bus4.en = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      exp_v = (sb.size() > 0) ? sb.pop_front() : 2'bxx;
      n_chk++;
      if ({bus1.out, bus1.period_start} !== exp_v) begin
        n_fail++;
        $display("FAIL p4_idle_sb cyc %0d: got %b want %b", i, {bus1.out, bus1.period_start}, exp_v);
      end
      if (bus4.out === 1'b1) begin
        if (i < 512) hi0++;
        else hi1++;
      end
      if (bus4.period_start === 1'b1) begin
        psn++;
        if (ps_first < 0) ps_first = i;
        ps_last = i;
      end
    end
    n_chk++;
    if (hi0 !== 64 || hi1 !== 64) begin
      n_fail++;
      $display("FAIL p4_highs: got %0d/%0d want 64/64", hi0, hi1);
    end
    n_chk++;
    if (psn !== 2 || ps_first !== 511 || ps_last !== 1023) begin
      n_fail++;
      $display("FAIL p4_pulses: got n=%0d at %0d,%0d want n=2 at 511,1023", psn, ps_first, ps_last);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    bus1.en = 1'b0;
    bus1.value_input = '0;
    bus4.en = 1'b0;
    bus4.value_input = '0;
    test_reset();
    test_duty(32, 1'b1, 32);
    test_duty(0, 1'b0, 0);
    test_duty(127, 1'b0, 127);
    test_mid_change();
    test_en_drop();
    test_reset_mid();
    test_prescale();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
